// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
//   Shared definitions for the mac unit and its upstream sequencer.
//   - mac_seq_state_t : sequencer FSM state encoding
//   - pipeline latency constants used to align the mac enables
//   - MAX_LEN         : largest dot-product length that cannot overflow the
//                       22-bit accumulator with 8-bit unsigned operands
//   - EN_PIPE_DEPTH   : depth of the enable alignment shift register
//   - acc_width_need  : accumulator width needed for a given operand width/length
// -----------------------------------------------------------------------------
package mac_pkg;

  // Operand memories return data one cycle after the read strobe.
  localparam int MEM_RD_LAT = 1;
  // The mac multiplier registers its product one cycle after mul_mem_en.
  localparam int MUL_LAT    = 1;
  // The accumulator register updates one cycle after ac_mem_en.
  localparam int ACC_LAT    = 1;

  // 64 * 255 * 255 = 4161600 < 2^22
  localparam int MAX_LEN    = 64;

  // mul enable sits MEM_RD_LAT behind the read strobe, accumulate enable a
  // further MUL_LAT behind that.
  localparam int EN_PIPE_DEPTH = MEM_RD_LAT + MUL_LAT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } mac_seq_state_t;

  // Bits needed to hold a sum of max_len products of two in_w-bit unsigned
  // operands.
  function automatic int acc_width_need(input int in_w, input int max_len);
    return 2 * in_w + $clog2(max_len);
  endfunction

endpackage

// File: rtl/mac_en_pipe.sv
// -----------------------------------------------------------------------------
// mac_en_pipe
//   Delay line for the operand read strobe. Bit i of q is d delayed by i+1
//   clock cycles, so the sequencer can tap the mul and accumulate enables
//   at the latencies of the memory and multiplier stages.
//
// Parameters
//   DEPTH  number of delay stages (>= 1)
//
// Ports
//   clk    in   1          clock
//   rst_n  in   1          asynchronous active-low reset (clears all stages)
//   d      in   1          enable to be delayed
//   q      out  DEPTH      q[i] = d delayed i+1 cycles
// -----------------------------------------------------------------------------
module mac_en_pipe #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  output logic [DEPTH-1:0] q
);

  logic [DEPTH-1:0] en_p;

  if (DEPTH == 1) begin : g_single
    // stage 0 -> 1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_p <= '0;
      end else begin
        en_p <= d;
      end
    end
  end else begin : g_multi
    // stage i -> i+1 for every tap, new sample enters at bit 0
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_p <= '0;
      end else begin
        en_p <= {en_p[DEPTH-2:0], d};
      end
    end
  end

  assign q = en_p;

endmodule

// File: rtl/mac_seq.sv
// -----------------------------------------------------------------------------
// mac_seq
//   Upstream sequencer for a single mac unit. One job computes the dot
//   product of len terms read from an image memory and a weight memory
//   (both with one cycle of read latency). The sequencer clears the mac,
//   streams the operand addresses, aligns the mac enables with the memory
//   and multiplier latency, waits for the accumulator to settle, captures
//   mac_out and offers it downstream with a valid/ready handshake.
//
// Parameters
//   IN_WIDTH    operand width
//   OUT_WIDTH   accumulator / result width
//   ADDR_WIDTH  operand memory address width (addresses wrap)
//   LEN_WIDTH   width of len_in
//   MAX_LEN     largest accepted length; larger requests raise err
//
// Ports
//   clk          in   1           clock
//   rst_n        in   1           asynchronous active-low reset
//   start        in   1           job request, only looked at in IDLE
//   len_in       in   LEN_WIDTH   number of terms (0..MAX_LEN)
//   img_base     in   ADDR_WIDTH  first image address
//   wgt_base     in   ADDR_WIDTH  first weight address
//   busy         out  1           high whenever the FSM is not IDLE
//   err          out  1           one-cycle pulse: request rejected
//   mem_rd_en    out  1           read strobe to both operand memories
//   img_addr     out  ADDR_WIDTH  image memory address
//   wgt_addr     out  ADDR_WIDTH  weight memory address
//   mac_rst_mem  out  1           mac accumulator clear
//   mac_mul_en   out  1           mac multiplier enable
//   mac_ac_en    out  1           mac accumulate enable
//   mac_out      in   OUT_WIDTH   mac accumulator value
//   res_valid    out  1           result available
//   res_ready    in   1           downstream accepts the result
//   res_data     out  OUT_WIDTH   captured dot product
// -----------------------------------------------------------------------------
module mac_seq
  import mac_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 22,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 7,
  parameter int MAX_LEN    = mac_pkg::MAX_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic [ADDR_WIDTH-1:0] img_base,
  input  logic [ADDR_WIDTH-1:0] wgt_base,
  output logic                  busy,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] img_addr,
  output logic [ADDR_WIDTH-1:0] wgt_addr,
  output logic                  mac_rst_mem,
  output logic                  mac_mul_en,
  output logic                  mac_ac_en,
  input  logic [OUT_WIDTH-1:0]  mac_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OUT_WIDTH-1:0]  res_data
);

  // A result width too narrow for the longest job would silently wrap.
  if (OUT_WIDTH < acc_width_need(IN_WIDTH, MAX_LEN)) begin : g_width_guard
    $error("mac_seq: OUT_WIDTH too small for IN_WIDTH and MAX_LEN");
  end

  localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
  localparam logic [1:0]           ACC_LAT_L = 2'(ACC_LAT);
  localparam int                   MUL_TAP   = MEM_RD_LAT - 1;
  localparam int                   AC_TAP    = EN_PIPE_DEPTH - 1;

  // ---------------------------------------------------------------------------
  // State and job registers
  // ---------------------------------------------------------------------------
  mac_seq_state_t state_q;
  mac_seq_state_t state_d;

  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  term_q;
  logic [1:0]            settle_cnt;
  logic [ADDR_WIDTH-1:0] img_base_q;
  logic [ADDR_WIDTH-1:0] wgt_base_q;

  logic                  len_ok;
  logic                  accept;
  logic                  last_term;
  logic                  pipe_idle;
  logic [EN_PIPE_DEPTH-1:0] en_pipe_q;

  // Next values of the registered outputs
  logic                  busy_d;
  logic                  err_d;
  logic                  mem_rd_en_d;
  logic [ADDR_WIDTH-1:0] img_addr_d;
  logic [ADDR_WIDTH-1:0] wgt_addr_d;
  logic                  mac_rst_mem_d;
  logic                  res_valid_d;
  logic [OUT_WIDTH-1:0]  res_data_d;

  assign len_ok    = (len_in <= MAX_LEN_L);
  assign accept    = (state_q == ST_IDLE) && start && len_ok;
  assign last_term = (term_q == (len_q - LEN_WIDTH'(1)));
  // Nothing is still travelling through the memory / multiplier / adder path.
  assign pipe_idle = !mem_rd_en && !mac_mul_en && !mac_ac_en;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = (len_q != '0) ? ST_ISSUE : ST_DRAIN;
      end
      ST_ISSUE: begin
        if (last_term) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // settle_cnt counts cycles since the last accumulate landed.
        if (settle_cnt == ACC_LAT_L) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_valid && res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (every output is registered from these next values)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d        = (state_d != ST_IDLE);
    err_d         = (state_q == ST_IDLE) && start && !len_ok;
    mem_rd_en_d   = (state_d == ST_ISSUE);
    mac_rst_mem_d = (state_d == ST_CLEAR);
    res_valid_d   = (state_d == ST_HOLD);

    img_addr_d = img_addr;
    wgt_addr_d = wgt_addr;
    if ((state_q == ST_CLEAR) && (state_d == ST_ISSUE)) begin
      img_addr_d = img_base_q;
      wgt_addr_d = wgt_base_q;
    end else if ((state_q == ST_ISSUE) && (state_d == ST_ISSUE)) begin
      // natural wrap at 2^ADDR_WIDTH
      img_addr_d = img_addr + ADDR_WIDTH'(1);
      wgt_addr_d = wgt_addr + ADDR_WIDTH'(1);
    end

    res_data_d = res_data;
    if ((state_q == ST_DRAIN) && (state_d == ST_HOLD)) begin
      res_data_d = mac_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      err         <= 1'b0;
      mem_rd_en   <= 1'b0;
      img_addr    <= '0;
      wgt_addr    <= '0;
      mac_rst_mem <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= '0;
    end else begin
      busy        <= busy_d;
      err         <= err_d;
      mem_rd_en   <= mem_rd_en_d;
      img_addr    <= img_addr_d;
      wgt_addr    <= wgt_addr_d;
      mac_rst_mem <= mac_rst_mem_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Job control: length, term counter, drain settle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      term_q     <= '0;
      settle_cnt <= '0;
    end else begin
      if (accept) len_q <= len_in;

      if (state_q == ST_CLEAR) begin
        term_q <= '0;
      end else if (state_q == ST_ISSUE) begin
        term_q <= term_q + LEN_WIDTH'(1);
      end

      if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN) && pipe_idle) begin
        settle_cnt <= settle_cnt + 2'd1;
      end else begin
        settle_cnt <= '0;
      end
    end
  end

  // Base addresses are pure data, only meaningful after accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      img_base_q <= img_base;
      wgt_base_q <= wgt_base;
    end
  end

  // ---------------------------------------------------------------------------
  // Enable alignment: read strobe -> mul enable -> accumulate enable
  // ---------------------------------------------------------------------------
  mac_en_pipe #(
    .DEPTH (EN_PIPE_DEPTH)
  ) u_en_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mem_rd_en),
    .q     (en_pipe_q)
  );

  assign mac_mul_en = en_pipe_q[MUL_TAP];
  assign mac_ac_en  = en_pipe_q[AC_TAP];

endmodule

// File: tb/tb_mac_seq.sv
module tb_mac_seq;

  localparam int IN_W  = 8;
  localparam int OUT_W = 22;
  localparam int AW    = 10;
  localparam int LW    = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LW-1:0]    len_in;
  logic [AW-1:0]    img_base;
  logic [AW-1:0]    wgt_base;
  logic             busy;
  logic             err;
  logic             mem_rd_en;
  logic [AW-1:0]    img_addr;
  logic [AW-1:0]    wgt_addr;
  logic             mac_rst_mem;
  logic             mac_mul_en;
  logic             mac_ac_en;
  logic [OUT_W-1:0] mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;

  always #5 clk = ~clk;

  mac_seq #(
    .IN_WIDTH   (IN_W),
    .OUT_WIDTH  (OUT_W),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .MAX_LEN    (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len_in      (len_in),
    .img_base    (img_base),
    .wgt_base    (wgt_base),
    .busy        (busy),
    .err         (err),
    .mem_rd_en   (mem_rd_en),
    .img_addr    (img_addr),
    .wgt_addr    (wgt_addr),
    .mac_rst_mem (mac_rst_mem),
    .mac_mul_en  (mac_mul_en),
    .mac_ac_en   (mac_ac_en),
    .mac_out     (mac_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data)
  );

  // Operand ROMs, one cycle read latency
  logic [7:0] img_rom [1024];
  logic [7:0] wgt_rom [1024];
  logic [7:0] img_q = 8'd0;
  logic [7:0] wgt_q = 8'd0;

  always_ff @(posedge clk) begin
    if (mem_rd_en) begin
      img_q <= img_rom[img_addr];
      wgt_q <= wgt_rom[wgt_addr];
    end
  end

  // mac: registered product, registered accumulator, synchronous clear
  logic [15:0]      prod = 16'd0;
  logic [OUT_W-1:0] acc  = '0;

  always_ff @(posedge clk) begin
    if (mac_rst_mem) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (mac_mul_en) prod <= 16'(img_q) * 16'(wgt_q);
      if (mac_ac_en)  acc  <= acc + OUT_W'(prod);
    end
  end

  assign mac_out = acc;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int len;
    int ib;
    int wb;
    int exp;
    bit chk_lat;
  } vec_t;

  vec_t tbl[6];

  // Runs one job; hold>0 keeps res_ready low for that many cycles once the
  // result is up, poking start meanwhile.
  task automatic run_job(input vec_t v, input int hold, input string tag);
    int c;
    int rd;
    int mul;
    int ac;
    int busy_bad;
    int hold_bad;
    bit seen;
    logic [OUT_W-1:0] held;
    c = 0; rd = 0; mul = 0; ac = 0; busy_bad = 0; hold_bad = 0; seen = 1'b0;
    res_ready = (hold == 0);
    start     = 1'b1;
    len_in    = LW'(v.len);
    img_base  = AW'(v.ib);
    wgt_base  = AW'(v.wb);
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen && c < 200) begin
      if (mem_rd_en) begin
        check({tag, " img_addr"}, int'(img_addr), (v.ib + rd) % 1024);
        check({tag, " wgt_addr"}, int'(wgt_addr), (v.wb + rd) % 1024);
        rd++;
      end
      if (mac_mul_en) mul++;
      if (mac_ac_en)  ac++;
      if (busy !== 1'b1) busy_bad++;
      if (res_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    check({tag, " res_valid seen"}, int'(seen), 1);
    if (v.chk_lat) check({tag, " latency"}, c, v.len + 5);
    check({tag, " res_data"}, int'(res_data), v.exp);
    check({tag, " rd_en count"}, rd, v.len);
    check({tag, " mul_en count"}, mul, v.len);
    check({tag, " ac_en count"}, ac, v.len);
    check({tag, " busy low during job"}, busy_bad, 0);
    if (hold > 0) begin
      held = res_data;
      for (int i = 0; i < hold; i++) begin
        start  = 1'b1;
        len_in = LW'(4);
        @(posedge clk); #1;
        if (res_valid !== 1'b1 || res_data !== held || busy !== 1'b1 || err !== 1'b0)
          hold_bad++;
      end
      check({tag, " hold stable"}, hold_bad, 0);
      start     = 1'b0;
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, " valid dropped"}, int'(res_valid), 0);
    check({tag, " busy dropped"}, int'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    bit found;
    vec_t v;

    for (int i = 0; i < 1024; i++) begin
      img_rom[i] = 8'd0;
      wgt_rom[i] = 8'd0;
    end
    img_rom[0] = 8'd1; img_rom[1] = 8'd2; img_rom[2] = 8'd3; img_rom[3] = 8'd4;
    wgt_rom[0] = 8'd5; wgt_rom[1] = 8'd6; wgt_rom[2] = 8'd7; wgt_rom[3] = 8'd8;
    for (int i = 100; i < 164; i++) begin
      img_rom[i] = 8'd255;
      wgt_rom[i] = 8'd255;
    end
    img_rom[1022] = 8'd3; img_rom[1023] = 8'd4;
    for (int i = 200; i < 204; i++) wgt_rom[i] = 8'd1;
    img_rom[300] = 8'd3; img_rom[301] = 8'd3;
    wgt_rom[300] = 8'd3; wgt_rom[301] = 8'd3;
    img_rom[400] = 8'd10; wgt_rom[400] = 8'd20;
    img_rom[500] = 8'd7; img_rom[501] = 8'd8; img_rom[502] = 8'd9;
    wgt_rom[600] = 8'd1; wgt_rom[601] = 8'd2; wgt_rom[602] = 8'd3;

    //            len  ib   wb   exp      lat
    tbl[0] = '{   4,   0,   0,       70, 1'b1};
    tbl[1] = '{  64, 100, 100,  4161600, 1'b1};
    tbl[2] = '{  64, 100, 100,  4161600, 1'b1};
    tbl[3] = '{   0,   0,   0,        0, 1'b0};
    tbl[4] = '{   1, 400, 400,      200, 1'b1};
    tbl[5] = '{   3, 500, 600,       50, 1'b1};

    rst_n     = 1'b0;
    start     = 1'b0;
    len_in    = '0;
    img_base  = '0;
    wgt_base  = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset err", int'(err), 0);
    check("reset mem_rd_en", int'(mem_rd_en), 0);
    check("reset mac_rst_mem", int'(mac_rst_mem), 1);
    check("reset mul_en", int'(mac_mul_en), 0);
    check("reset ac_en", int'(mac_ac_en), 0);
    check("reset res_valid", int'(res_valid), 0);
    check("reset res_data", int'(res_data), 0);
    check("reset img_addr", int'(img_addr), 0);
    check("reset wgt_addr", int'(wgt_addr), 0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle mac_rst_mem", int'(mac_rst_mem), 0);

    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i], 0, $sformatf("vec%0d", i));
    end

    // Oversized request: rejected with a one-cycle err
    start  = 1'b1;
    len_in = LW'(65);
    @(posedge clk); #1;
    start = 1'b0;
    check("len65 err pulse", int'(err), 1);
    check("len65 busy", int'(busy), 0);
    check("len65 mac_rst_mem", int'(mac_rst_mem), 0);
    @(posedge clk); #1;
    check("len65 err cleared", int'(err), 0);
    check("len65 busy after", int'(busy), 0);
    check("len65 mem_rd_en", int'(mem_rd_en), 0);

    // Address wrap plus downstream back-pressure
    v = '{4, 1022, 200, 10, 1'b1};
    run_job(v, 10, "wrap_hold");
    repeat (2) @(posedge clk);
    #1;
    check("no queued job", int'(busy), 0);

    // Reset in the middle of ISSUE, at term 2
    start    = 1'b1;
    len_in   = LW'(4);
    img_base = AW'(0);
    wgt_base = AW'(0);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    found = 1'b0;
    while (!found && k < 20) begin
      if (mem_rd_en && int'(img_addr) == 2) found = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("reached term 2", int'(found), 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort mem_rd_en", int'(mem_rd_en), 0);
    check("abort mac_rst_mem", int'(mac_rst_mem), 1);
    check("abort mul_en", int'(mac_mul_en), 0);
    check("abort ac_en", int'(mac_ac_en), 0);
    check("abort res_valid", int'(res_valid), 0);
    check("abort img_addr", int'(img_addr), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{2, 300, 300, 18, 1'b1};
    run_job(v, 0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
